// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encoding, sizing constants and select-width helper
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_REQ_DEFAULT = 32;
    localparam int SEL_W_DEFAULT = sel_width(N_REQ_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after start, wrapping modulo N_REQ;
// with excl_i set, the start position itself is never chosen
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int SEL_W = sel_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] start_i,
    input  logic             excl_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Walk backwards so the nearest candidate to start wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int p;
            p = int'(start_i) + k;
            p = (p >= N_REQ) ? p - N_REQ : p;
            if (req_i[p] && !(excl_i && k == 0)) begin
                found_o = 1'b1;
                idx_o   = SEL_W'(p);
            end
        end
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin select arbiter for a shared N_REQ:1 mux,
// with a hold timeout that forces rotation under contention
module mux_select_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEFAULT,
    parameter int SEL_W    = sel_width(N_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] REQ,
    output logic [SEL_W-1:0] S,
    output logic [N_REQ-1:0] GNT,
    output logic             VALID,
    output logic             TIMEOUT
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_TOP = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t           state_q;
    logic [SEL_W-1:0] s_q, last_q;
    logic [HW-1:0]    hold_q;
    logic [N_REQ-1:0] gnt_q;
    logic             valid_q, timeout_q;

    logic             owner_req_d, others_d, force_d, found_d;
    logic [SEL_W-1:0] start_d, next_idx_d;

    assign owner_req_d = REQ[s_q];
    assign others_d    = |(REQ & ~(N_REQ'(1) << s_q));
    assign force_d     = (state_q == GRANT) && owner_req_d && (MAX_HOLD != 0) &&
                         (hold_q == HOLD_TOP) && others_d;
    // A forced rotation starts at the owner with the owner excluded, which
    // is the same order as LAST+1 onward but never lands back on the owner.
    assign start_d     = force_d ? last_q :
                         (last_q == SEL_W'(N_REQ - 1)) ? '0 : last_q + SEL_W'(1);

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
        .req_i   (REQ),
        .start_i (start_d),
        .excl_i  (force_d),
        .found_o (found_d),
        .idx_o   (next_idx_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_q       <= '0;
            last_q    <= SEL_W'(N_REQ - 1);
            hold_q    <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if ((state_q == IDLE && found_d) || force_d ||
                (state_q == GRANT && !owner_req_d && found_d)) begin
                state_q   <= GRANT;
                s_q       <= next_idx_d;
                last_q    <= next_idx_d;
                gnt_q     <= N_REQ'(1) << next_idx_d;
                valid_q   <= 1'b1;
                hold_q    <= '0;
                timeout_q <= force_d;
            end else if (state_q == GRANT && owner_req_d) begin
                hold_q <= !others_d ? '0 :
                          (hold_q == HOLD_TOP) ? hold_q : hold_q + HW'(1);
            end else if (state_q == GRANT) begin
                state_q <= IDLE;
                gnt_q   <= '0;
                valid_q <= 1'b0;
                hold_q  <= '0;
            end
        end
    end

    assign S       = s_q;
    assign GNT     = gnt_q;
    assign VALID   = valid_q;
    assign TIMEOUT = timeout_q;

endmodule
